// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART_TX arbiter: state encoding, tag base
// and the round-robin one-hot pick used by rr_arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_LOAD       = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_DONE  = 3'd4,
        S_DRAIN      = 3'd5,
        S_HOLD       = 3'd6,
        S_TAG_LOAD   = 3'd7
    } state_t;

    localparam logic [7:0] TAG_BASE = 8'hA0;
    localparam int         MAX_REQ  = 8;

    // First set bit at or after ptr, wrapping within the low n bits.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [2:0]         idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = 3'((int'(ptr) + i) % n);
            if (i < n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// pointer moves to winner+1 when the owner strobes advance.
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic [2:0]         ptr;
    logic [2:0]         win_idx;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick_hi;

    assign pick           = rr_pick(8'(req), ptr, NUM_REQ);
    assign grant          = pick[NUM_REQ-1:0];
    assign win_idx        = onehot_idx(pick);
    assign unused_pick_hi = ^(pick >> NUM_REQ);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            ptr <= '0;
        end else if (advance && |pick) begin
            ptr <= (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between NUM_REQ byte producers, one burst per grant.
// Optional UART_TX_CHAN_TAG_EN: send 8'hA0|owner before each granted burst.
//
// state        | meaning
// S_IDLE       | no owner; arbitrate once the transmitter is quiet
// S_FETCH      | accept one byte from the owner (ready for this cycle only)
// S_LOAD       | pulse DV with the captured byte
// S_TAG_LOAD   | pulse DV with the channel tag (tag build only)
// S_WAIT_START | wait for transmitter Active
// S_WAIT_DONE  | wait for transmitter Done
// S_DRAIN      | wait until Done and Active are both low, then release or hold
// S_HOLD       | owner keeps grant, waiting for its next byte
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Data,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy
);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] arb_grant, grant_nxt;
    logic [7:0]         byte_nxt, burst_cnt, cnt_nxt, g_data;
    logic               last_q, last_nxt;
    logic               arb_advance, tx_quiet, g_valid, g_last, burst_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .req     (i_Req_Valid),
        .advance (arb_advance),
        .grant   (arb_grant)
    );

`ifdef UART_TX_CHAN_TAG_EN
    logic       tag_sent, tag_nxt;
    logic [2:0] arb_idx;

    assign arb_idx = onehot_idx(8'(arb_grant));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) tag_sent <= 1'b0;
        else         tag_sent <= tag_nxt;
    end
`endif

    assign tx_quiet  = !i_Tx_Active && !i_Tx_Done;
    assign g_valid   = |(i_Req_Valid & o_Grant);
    assign g_last    = |(i_Req_Last & o_Grant);
    assign burst_end = last_q || (burst_cnt == 8'(MAX_BURST));

    always_comb begin
        g_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_Grant[k]) g_data = g_data | i_Req_Data[8*k +: 8];
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = o_Grant;
        byte_nxt    = o_Tx_Byte;
        last_nxt    = last_q;
        cnt_nxt     = burst_cnt;
        arb_advance = 1'b0;
`ifdef UART_TX_CHAN_TAG_EN
        tag_nxt     = tag_sent;
`endif
        case (state)
            S_IDLE: begin
                if (|i_Req_Valid && tx_quiet) begin
                    arb_advance = 1'b1;
                    grant_nxt   = arb_grant;
`ifdef UART_TX_CHAN_TAG_EN
                    byte_nxt    = TAG_BASE | {5'd0, arb_idx};
                    state_nxt   = S_TAG_LOAD;
`else
                    state_nxt   = S_FETCH;
`endif
                end
            end
            S_FETCH: begin
`ifdef UART_TX_CHAN_TAG_EN
                tag_nxt = 1'b0;
`endif
                // A producer that dropped valid after the grant just waits in S_HOLD.
                if (g_valid) begin
                    byte_nxt  = g_data;
                    last_nxt  = g_last;
                    cnt_nxt   = burst_cnt + 8'd1;
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            S_LOAD: state_nxt = S_WAIT_START;
            S_TAG_LOAD: begin
`ifdef UART_TX_CHAN_TAG_EN
                tag_nxt = 1'b1;
`endif
                state_nxt = S_WAIT_START;
            end
            S_WAIT_START: if (i_Tx_Active) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE:  if (i_Tx_Done)   state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (tx_quiet) begin
`ifdef UART_TX_CHAN_TAG_EN
                    if (tag_sent) begin
                        state_nxt = S_FETCH;
                    end else
`endif
                    if (burst_end) begin
                        grant_nxt = '0;
                        cnt_nxt   = '0;
                        last_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD:  if (g_valid) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            o_Grant   <= '0;
            o_Tx_Byte <= '0;
            last_q    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            o_Grant   <= grant_nxt;
            o_Tx_Byte <= byte_nxt;
            last_q    <= last_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    assign o_Tx_DV     = (state == S_LOAD) || (state == S_TAG_LOAD);
    assign o_Req_Ready = (state == S_FETCH) ? o_Grant : '0;
    assign o_Busy      = (state != S_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART_TX transmitter between NUM_REQ byte-stream requesters.
Round-robin arbitration per burst; grant held until requester flags last byte or MAX_BURST bytes sent.
Sequences the transmitter's DV/Active/Done handshake so no byte is issued while the transmitter is in stop or cleanup.
Sits between on-chip byte producers (debug, status, echo) and the single UART_TX instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max data bytes per grant before forced release (1..255)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Req_Valid  in  NUM_REQ  per-requester byte valid
i_Req_Data  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
i_Req_Last  in  NUM_REQ  byte is last of burst; qualified with valid
o_Req_Ready  out  NUM_REQ  one-hot byte accept; transfer = valid & ready
o_Grant  out  NUM_REQ  one-hot current owner, zero when idle
o_Tx_DV  out  1  to UART_TX i_Tx_DV, 1-cycle pulse
o_Tx_Byte  out  8  to UART_TX i_Tx_Byte, stable from DV until Done
i_Tx_Active  in  1  from UART_TX o_Tx_Active
i_Tx_Done  in  1  from UART_TX o_Tx_Done
o_Busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset: all outputs 0. State S_IDLE. RR pointer 0 (requester 0 highest priority). Burst count 0.
- Arbitration happens only in S_IDLE. Requires i_Tx_Active=0 and i_Tx_Done=0, so a byte in flight across reset drains first.
- Winner is the first valid at or after the pointer, wrapping. o_Grant is registered next cycle. Pointer = winner+1 mod NUM_REQ, updated on grant.
- States:
  - S_IDLE -> S_FETCH when any valid and the transmitter is quiet.
  - S_FETCH: o_Req_Ready[g]=1 for exactly this cycle. Capture data into o_Tx_Byte and last into a register. Increment burst count. -> S_LOAD.
  - S_LOAD: o_Tx_DV=1 for one cycle. -> S_WAIT_START.
  - S_WAIT_START: wait i_Tx_Active=1. -> S_WAIT_DONE.
  - S_WAIT_DONE: wait i_Tx_Done=1. -> S_DRAIN.
  - S_DRAIN: wait i_Tx_Done=0 and i_Tx_Active=0. Then:
    - last captured, or burst count==MAX_BURST: clear grant, count=0 -> S_IDLE.
    - otherwise -> S_HOLD.
  - S_HOLD: grant kept. On valid[g] -> S_FETCH. Other requesters wait indefinitely; the burst is bounded only by MAX_BURST.
- Latency: valid sampled in S_IDLE at cycle t; ready at t+1; DV at t+2.
- Back-to-back bytes in one burst: next DV is 3 cycles after Done falls (S_DRAIN exit, S_HOLD/S_FETCH, S_LOAD), assuming valid is held.
- The FETCH path goes through S_HOLD, so one byte is in flight at most.
- Valid deassert in S_HOLD is legal. Last without a prior byte is a 1-byte burst.
- Simultaneous valids in S_IDLE: only the RR winner is granted. Losers see no ready.
- Forced release at MAX_BURST: requester's next byte competes in RR as a new burst.
- Reset mid-operation: state, grant and count clear on the next edge, and o_Tx_DV drops. The transmitter has no reset; S_IDLE's quiet check absorbs its in-flight frame.

Optional Feature:
UART_TX_CHAN_TAG_EN
- Defined: on each grant, before the first S_FETCH, the block sends tag byte 8'hA0 | g[2:0].
  - Path: S_TAG_LOAD (DV with tag) -> S_WAIT_START -> S_WAIT_DONE -> S_DRAIN -> S_FETCH.
  - The tag is not counted toward MAX_BURST.
  - A forced release followed by re-grant sends a new tag.
- Undefined: S_TAG_LOAD is absent and no tag bytes are sent. Timing is as above.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state encoding (3 bits covers 8 states incl. S_TAG_LOAD)
  - TAG_BASE = 8'hA0
  - function for RR one-hot selection.
- Sub-module rr_arbiter (NUM_REQ): request vector, pointer register and advance strobe in; one-hot grant out. Reusable for other shared UART resources.

Test Plan:
- Reset, then valid[2]=1 with data 8'h55, last=1 -> ready[2] at t+1, DV at t+2 with byte 8'h55, grant[2] clears after Done falls, o_Busy back to 0.
- Valid[0], valid[1] and valid[3] all asserted together, each sending a 1-byte burst -> serial order 0,1,3. Pointer then 0; a new valid[0]|valid[1] gives requester 0.
- Requester 1 sends 20 bytes with no last, MAX_BURST=16, valid[2] pending -> 16 bytes from 1, then the burst from 2, then the remaining 4 from 1.
- Requester 0 sends a 3-byte burst with 0x01,0x02,0x03, last on 0x03 -> three frames in order, grant held throughout, DV spacing = 3 cycles after each Done fall.
- i_Reset pulsed during S_WAIT_DONE with valid[1] held -> DV low and grant 0 next cycle; no new DV until the transmitter's Active/Done are both 0; then requester 1 is re-granted.
- UART_TX_CHAN_TAG_EN defined, requester 3 sends 8'h7E with last=1 -> line carries 8'hA3 then 8'h7E; burst count 1.
